hawk_axiwr_initiator: RTL and testbench

//  AXI4 write initiator between hawk_pgwr_mngr and the DDR AXI port.
//  - Takes axi_wr_reqpkt_t (independent AW/W valids) from the manager.
//  - Issues single-beat 64B bursts on AW/W and collects B responses.
//  - Returns axi_wr_rdypkt_t and axi_wr_resppkt_t to the manager.
//  - Bounds outstanding writes; optionally applies the 8-byte byteswap to data/strb.

---
 rtl/hacd_pkg.sv | 65 ++++++
 rtl/hawk_axiwr_initiator_if.sv | 35 +++
 rtl/hawk_skid_buf.sv | 71 +++++++
 rtl/hawk_axiwr_initiator.sv | 113 +++++++++++
 tb/tb_hawk_axiwr_initiator.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hacd_pkg.sv
// Shared types, constants and lane-swap helpers for the hawk DDR write path.
// Imported by the AXI write initiator, its skid buffers and its bus interface.
package hacd_pkg;

    localparam int HACD_AXI4_ID_WIDTH   = 4;
    localparam int HACD_AXI4_ADDR_WIDTH = 64;
    localparam int HACD_AXI4_LEN_WIDTH  = 8;
    localparam int HACD_AXI4_DATA_WIDTH = 512;
    localparam int HACD_AXI4_STRB_WIDTH = 64;

    localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
        logic [HACD_AXI4_DATA_WIDTH-1:0] data;
        logic [HACD_AXI4_STRB_WIDTH-1:0] strb;
        logic                            awvalid;
        logic                            wvalid;
    } axi_wr_reqpkt_t;

    typedef struct packed {
        logic awready;
        logic wready;
    } axi_wr_rdypkt_t;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } axi_wr_resppkt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    function automatic logic [511:0] get_8byte_byteswap(
        input logic [511:0] d
    );
        logic [511:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            for (int b = 0; b < 8; b++) begin
                r[l*64 + b*8 +: 8] = d[l*64 + (7-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] get_strb_swap(
        input logic [63:0] s
    );
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 8; l++) begin
            for (int b = 0; b < 8; b++) begin
                r[l*8 + b] = s[l*8 + 7 - b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hawk_axiwr_initiator_if.sv
// AXI4 write-channel bundle (AW/W/B) between the initiator and DDR.
// master = initiator side, slave = memory side.
interface hawk_axiwr_initiator_if;
    import hacd_pkg::*;

    logic [HACD_AXI4_ID_WIDTH-1:0]   awid;
    logic [HACD_AXI4_ADDR_WIDTH-1:0] awaddr;
    logic [HACD_AXI4_LEN_WIDTH-1:0]  awlen;
    logic [2:0]                      awsize;
    logic [1:0]                      awburst;
    logic                            awvalid;
    logic                            awready;
    logic [HACD_AXI4_DATA_WIDTH-1:0] wdata;
    logic [HACD_AXI4_STRB_WIDTH-1:0] wstrb;
    logic                            wlast;
    logic                            wvalid;
    logic                            wready;
    logic [HACD_AXI4_ID_WIDTH-1:0]   bid;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );

endinterface

// File: rtl/hawk_skid_buf.sv
// Two-entry valid/ready buffer; in_ready depends only on registered state,
// so upstream never sees a combinational path from the downstream ready.
module hawk_skid_buf
    import hacd_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             push, pop;

    assign in_ready_o  = (state_q != SKID_FULL);
    assign out_valid_o = (state_q != SKID_EMPTY);
    assign out_data_o  = e0_q;
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    // e0 is always the head; e1 only holds the second entry when FULL
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        unique case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    e0_d    = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    e0_d = in_data_i;
                end else if (push) begin
                    e1_d    = in_data_i;
                    state_d = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    e0_d    = e1_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

endmodule

// File: rtl/hawk_axiwr_initiator.sv
// AXI4 single-beat 64B write initiator: buffers AW/W from the page-write
// manager, bounds outstanding writes and reports B responses back.
module hawk_axiwr_initiator
    import hacd_pkg::*;
#(
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BYTESWAP_EN     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  axi_wr_reqpkt_t        wr_reqpkt_i,
    output axi_wr_rdypkt_t        wr_rdypkt_o,
    output axi_wr_resppkt_t       wr_resppkt_o,
    hawk_axiwr_initiator_if.master m_axi,
    output logic                  wr_err_o,
    output logic                  idle_o
);

    localparam int WW = HACD_AXI4_DATA_WIDTH + HACD_AXI4_STRB_WIDTH;
    localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);
    localparam logic [HACD_AXI4_ID_WIDTH-1:0] AWID =
        HACD_AXI4_ID_WIDTH'(AXI_ID);

    logic            aw_rdy, aw_vld, aw_ok, aw_hs;
    logic            w_rdy, w_vld;
    logic            b_hs, b_live;
    logic [WW-1:0]   w_in, w_out;
    logic [3:0]      cnt_q, cnt_d;
    logic            bready_q;
    logic            err_q, err_d;
    axi_wr_resppkt_t resp_q, resp_d;
    logic            unused_bid;

    assign w_in = (BYTESWAP_EN != 0)
        ? {get_8byte_byteswap(wr_reqpkt_i.data),
           get_strb_swap(wr_reqpkt_i.strb)}
        : {wr_reqpkt_i.data, wr_reqpkt_i.strb};

    assign aw_ok = (cnt_q < CNT_MAX);

    hawk_skid_buf #(.WIDTH(HACD_AXI4_ADDR_WIDTH)) u_aw_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (wr_reqpkt_i.awvalid),
        .in_ready_o  (aw_rdy),
        .in_data_i   (wr_reqpkt_i.addr),
        .out_valid_o (aw_vld),
        .out_ready_i (m_axi.awready & aw_ok),
        .out_data_o  (m_axi.awaddr)
    );

    hawk_skid_buf #(.WIDTH(WW)) u_w_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (wr_reqpkt_i.wvalid),
        .in_ready_o  (w_rdy),
        .in_data_i   (w_in),
        .out_valid_o (w_vld),
        .out_ready_i (m_axi.wready),
        .out_data_o  (w_out)
    );

    assign m_axi.awid    = AWID;
    assign m_axi.awlen   = '0;
    assign m_axi.awsize  = AXI_SIZE_64B;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awvalid = aw_vld & aw_ok;
    assign m_axi.wdata   = w_out[WW-1 -: HACD_AXI4_DATA_WIDTH];
    assign m_axi.wstrb   = w_out[HACD_AXI4_STRB_WIDTH-1:0];
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = w_vld;
    assign m_axi.bready  = bready_q;

    assign wr_rdypkt_o.awready = aw_rdy;
    assign wr_rdypkt_o.wready  = w_rdy;
    assign wr_resppkt_o        = resp_q;
    assign wr_err_o            = err_q;
    assign idle_o = ~aw_vld & ~w_vld & (cnt_q == 4'd0);
    assign unused_bid          = ^m_axi.bid;

    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign b_hs   = m_axi.bvalid & bready_q;
    // B with nothing outstanding belongs to a write lost to reset
    assign b_live = b_hs & (cnt_q != 4'd0);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({aw_hs, b_live})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
        resp_d.bvalid = b_live;
        resp_d.bresp  = m_axi.bresp;
        err_d         = err_q | (b_live & m_axi.bresp[1]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= 4'd0;
            bready_q <= 1'b0;
            err_q    <= 1'b0;
            resp_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            bready_q <= 1'b1;
            err_q    <= err_d;
            resp_q   <= resp_d;
        end
    end

endmodule

// File: tb/tb_hawk_axiwr_initiator.sv
// Directed bench for hawk_axiwr_initiator: table-driven single writes plus
// hand-written ordering, backpressure, outstanding-cap and reset sequences.
module tb_hawk_axiwr_initiator;
    import hacd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    axi_wr_reqpkt_t  req, req0;
    axi_wr_rdypkt_t  rdy, rdy0;
    axi_wr_resppkt_t rsp, rsp0;
    logic            err, idle, err0, idle0;

    hawk_axiwr_initiator_if ax();
    hawk_axiwr_initiator_if ax0();

    hawk_axiwr_initiator #(
        .AXI_ID(0), .MAX_OUTSTANDING(4), .BYTESWAP_EN(1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_reqpkt_i(req), .wr_rdypkt_o(rdy), .wr_resppkt_o(rsp),
        .m_axi(ax.master), .wr_err_o(err), .idle_o(idle)
    );

    hawk_axiwr_initiator #(
        .AXI_ID(0), .MAX_OUTSTANDING(4), .BYTESWAP_EN(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst),
        .wr_reqpkt_i(req0), .wr_rdypkt_o(rdy0), .wr_resppkt_o(rsp0),
        .m_axi(ax0.master), .wr_err_o(err0), .idle_o(idle0)
    );

    typedef struct {
        logic [63:0]  addr;
        logic [511:0] data;
        logic [63:0]  strb;
        logic [511:0] exp_wdata;
        logic [63:0]  exp_wstrb;
    } vec_t;

    vec_t vt[5];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int ka, kw, whs, ahs, wcyc, acyc, peak, bad;
        int acc_a, acc_w;
        logic [63:0] aaddr;
        logic [7:0] bt;
        logic [63:0] aq[$];
        logic [511:0] wq[$];

        vt[0] = '{64'hFFF6100040,
            512'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20_2122232425262728_292A2B2C2D2E2F30_3132333435363738_393A3B3C3D3E3F40,
            64'hFFFF_FFFF_FFFF_FFFF,
            512'h0807060504030201_100F0E0D0C0B0A09_1817161514131211_201F1E1D1C1B1A19_2827262524232221_302F2E2D2C2B2A29_3837363534333231_403F3E3D3C3B3A39,
            64'hFFFF_FFFF_FFFF_FFFF};
        vt[1] = '{64'h80, 512'h0102030405060708, 64'h1,
            512'h0807060504030201, 64'h80};
        vt[2] = '{64'h1_0000_00C0, {440'h0, 8'hFF, 64'h0}, 64'h100,
            {384'h0, 8'hFF, 120'h0}, 64'h8000};
        vt[3] = '{64'h3FC0, {8'hAA, 504'h0}, 64'h8000_0000_0000_0000,
            {56'h0, 8'hAA, 448'h0}, 64'h0100_0000_0000_0000};
        vt[4] = '{64'h200, 512'h1122334455667788, 64'h0F,
            512'h8877665544332211, 64'hF0};

        req = '0;
        req0 = '0;
        ax.awready = 1'b1; ax.wready = 1'b1; ax.bvalid = 1'b0;
        ax.bresp = 2'b00; ax.bid = '0;
        ax0.awready = 1'b1; ax0.wready = 1'b1; ax0.bvalid = 1'b0;
        ax0.bresp = 2'b00; ax0.bid = '0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_awvalid", ax.awvalid, 0);
        chk("rst_wvalid", ax.wvalid, 0);
        chk("rst_rspvalid", rsp.bvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_idle", idle, 1);
        chk("rst_bready", ax.bready, 0);
        chk("rst_awready", rdy.awready, 1);
        chk("rst_wready", rdy.wready, 1);
        chk("rst_idle0", idle0, 1);
        chk("rst_err0", err0, 0);
        tick();
        chk("bready_up", ax.bready, 1);

        // table-driven single writes
        for (int v = 0; v < 5; v++) begin
            req.addr = vt[v].addr;
            req.data = vt[v].data;
            req.strb = vt[v].strb;
            req.awvalid = 1'b1;
            req.wvalid = 1'b1;
            tick();
            req.awvalid = 1'b0;
            req.wvalid = 1'b0;
            chk($sformatf("v%0d_awvalid", v), ax.awvalid, 1);
            chk($sformatf("v%0d_wvalid", v), ax.wvalid, 1);
            chk($sformatf("v%0d_awaddr", v), ax.awaddr, vt[v].addr);
            chk($sformatf("v%0d_wdata", v), ax.wdata, vt[v].exp_wdata);
            chk($sformatf("v%0d_wstrb", v), ax.wstrb, vt[v].exp_wstrb);
            chk($sformatf("v%0d_busy", v), idle, 0);
            tick();
            chk($sformatf("v%0d_aw_done", v), ax.awvalid, 0);
            ax.bvalid = 1'b1;
            ax.bresp = AXI_RESP_OKAY;
            tick();
            ax.bvalid = 1'b0;
            chk($sformatf("v%0d_rsp", v), rsp.bvalid, 1);
            chk($sformatf("v%0d_bresp", v), rsp.bresp, 0);
            chk($sformatf("v%0d_idle", v), idle, 1);
            tick();
            chk($sformatf("v%0d_rsp_pulse", v), rsp.bvalid, 0);
        end
        chk("awlen", ax.awlen, 0);
        chk("awsize", ax.awsize, 3'd6);
        chk("awburst", ax.awburst, 2'b01);
        chk("wlast", ax.wlast, 1);
        chk("awid", ax.awid, 0);
        chk("err_ok", err, 0);

        // W before AW, AW stalled by awready
        whs = 0; ahs = 0; wcyc = -1; acyc = -1; peak = 0; aaddr = '0;
        req.addr = 64'hFFF6100040;
        req.data = vt[1].data;
        req.strb = '1;
        for (int i = 0; i < 15; i++) begin
            req.wvalid = (i == 0);
            req.awvalid = (i == 5);
            ax.awready = (i >= 8);
            ax.bvalid = (i == 10);
            ax.bresp = AXI_RESP_OKAY;
            #1;
            if (ax.wvalid && ax.wready) begin
                whs++;
                if (wcyc < 0) wcyc = i;
            end
            if (ax.awvalid && ax.awready) begin
                ahs++;
                acyc = i;
                aaddr = ax.awaddr;
            end
            if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
            tick();
        end
        ax.awready = 1'b1;
        chk("wfirst_wcyc", wcyc, 1);
        chk("wfirst_acyc", acyc, 8);
        chk("wfirst_whs", whs, 1);
        chk("wfirst_ahs", ahs, 1);
        chk("wfirst_addr", aaddr, 64'hFFF6100040);
        chk("wfirst_peak", peak, 1);
        chk("wfirst_idle", idle, 1);

        // backpressure then drain
        ka = 0; kw = 0; bad = 0; acc_a = 0; acc_w = 0;
        for (int i = 0; i < 40; i++) begin
            ax.awready = (i >= 10);
            ax.wready = (i >= 10);
            req.awvalid = (ka < 4);
            req.addr = 64'h1000 + 64'(ka) * 64;
            req.wvalid = (kw < 4);
            bt = 8'(kw + 1);
            req.data = {64{bt}};
            req.strb = '1;
            #1;
            if (i >= 2 && i < 10 && (rdy.awready || rdy.wready)) bad++;
            if (req.awvalid && rdy.awready) ka++;
            if (req.wvalid && rdy.wready) kw++;
            if (ax.awvalid && ax.awready) aq.push_back(ax.awaddr);
            if (ax.wvalid && ax.wready) wq.push_back(ax.wdata);
            if (i == 9) begin
                acc_a = ka;
                acc_w = kw;
            end
            tick();
        end
        req.awvalid = 1'b0;
        req.wvalid = 1'b0;
        chk("bp_acc_aw", acc_a, 2);
        chk("bp_acc_w", acc_w, 2);
        chk("bp_rdy_low", bad, 0);
        chk("bp_aw_cnt", aq.size(), 4);
        chk("bp_w_cnt", wq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            bt = 8'(k + 1);
            chk($sformatf("bp_aw%0d", k),
                (k < aq.size()) ? aq[k] : 64'hx, 64'h1000 + 64'(k) * 64);
            chk($sformatf("bp_w%0d", k),
                (k < wq.size()) ? wq[k] : 512'hx, {64{bt}});
        end
        ax.bvalid = 1'b1;
        repeat (4) tick();
        ax.bvalid = 1'b0;
        tick();
        chk("bp_idle", idle, 1);

        // outstanding cap
        ka = 0; kw = 0; ahs = 0;
        for (int i = 0; i < 12; i++) begin
            req.awvalid = (ka < 5);
            req.addr = 64'h8000 + 64'(ka) * 64;
            req.wvalid = (kw < 5);
            req.data = 512'(kw);
            #1;
            if (req.awvalid && rdy.awready) ka++;
            if (req.wvalid && rdy.wready) kw++;
            if (ax.awvalid && ax.awready) ahs++;
            tick();
        end
        req.awvalid = 1'b0;
        req.wvalid = 1'b0;
        chk("cap_ahs", ahs, 4);
        chk("cap_awvalid_low", ax.awvalid, 0);
        chk("cap_cnt4", dut.cnt_q, 4);
        ax.bvalid = 1'b1;
        #1;
        chk("cap_hold_valid", ax.awvalid, 0);
        tick();
        chk("cap_5th_valid", ax.awvalid, 1);
        chk("cap_5th_addr", ax.awaddr, 64'h8100);
        tick();
        ax.bvalid = 1'b0;
        chk("cap_aw_b_same", dut.cnt_q, 3);
        chk("cap_drained", ax.awvalid, 0);
        ax.bvalid = 1'b1;
        repeat (3) tick();
        ax.bvalid = 1'b0;
        tick();
        chk("cap_cnt0", dut.cnt_q, 0);
        chk("cap_idle", idle, 1);

        // error response then reset with buffered writes
        req.addr = 64'h40;
        req.awvalid = 1'b1;
        req.wvalid = 1'b1;
        tick();
        req.awvalid = 1'b0;
        req.wvalid = 1'b0;
        tick();
        ax.bvalid = 1'b1;
        ax.bresp = 2'b10;
        tick();
        ax.bvalid = 1'b0;
        ax.bresp = AXI_RESP_OKAY;
        chk("err_rsp", rsp.bvalid, 1);
        chk("err_bresp", rsp.bresp, 2'b10);
        chk("err_set", err, 1);
        repeat (3) tick();
        chk("err_sticky", err, 1);
        req.awvalid = 1'b1;
        req.wvalid = 1'b1;
        tick();
        req.awvalid = 1'b0;
        req.wvalid = 1'b0;
        tick();
        ax.awready = 1'b0;
        ax.wready = 1'b0;
        req.awvalid = 1'b1;
        req.wvalid = 1'b1;
        repeat (2) tick();
        req.awvalid = 1'b0;
        req.wvalid = 1'b0;
        chk("pre_rst_full", rdy.awready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ax.awready = 1'b1;
        ax.wready = 1'b1;
        chk("rst2_awvalid", ax.awvalid, 0);
        chk("rst2_wvalid", ax.wvalid, 0);
        chk("rst2_rsp", rsp.bvalid, 0);
        chk("rst2_err", err, 0);
        chk("rst2_idle", idle, 1);
        tick();
        ax.bvalid = 1'b1;
        ax.bresp = 2'b10;
        tick();
        ax.bvalid = 1'b0;
        ax.bresp = AXI_RESP_OKAY;
        chk("late_b_rsp", rsp.bvalid, 0);
        chk("late_b_err", err, 0);
        chk("late_b_cnt", dut.cnt_q, 0);
        chk("late_b_idle", idle, 1);

        // pass-through instance
        req0.addr = 64'h40;
        req0.data = vt[0].data;
        req0.strb = 64'h0123_4567_89AB_CDEF;
        req0.awvalid = 1'b1;
        req0.wvalid = 1'b1;
        tick();
        req0.awvalid = 1'b0;
        req0.wvalid = 1'b0;
        chk("nosw_wdata", ax0.wdata, vt[0].data);
        chk("nosw_wstrb", ax0.wstrb, 64'h0123_4567_89AB_CDEF);
        chk("nosw_awaddr", ax0.awaddr, 64'h40);
        chk("nosw_rdy", rdy0.awready, 1);
        chk("nosw_rsp", rsp0.bvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
